ledr_pattern_sequencer: RTL and testbench

- Autonomous LED pattern engine in the Qsys system. The CPU configures it through an Avalon-MM slave.
- It drives the 10-bit LEDR PIO through an Avalon-MM master port wired to the PIO's s1 slave (address/chipselect/write_n/writedata).
- It steps the pattern every PERIOD clocks and issues one zero-wait write per update, offloading periodic LED writes from software.

---
 rtl/ledr_seq_pkg.sv | 31 +++
 rtl/ledr_step_counter.sv | 47 ++++
 rtl/ledr_pattern_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_ledr_pattern_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ledr_seq_pkg.sv
// Shared definitions for the LEDR pattern sequencer: slave register indices,
// pattern modes, bounce direction and push FSM states.
package ledr_seq_pkg;

  // Slave register indices
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_PATTERN = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // Pattern update modes, encoded exactly as CTRL[2:1]
  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  // Bounce direction, read back as STATUS[1]
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Master push FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PUSH = 1'b1
  } push_state_e;

endpackage

// File: rtl/ledr_step_counter.sv
// Step-period down-counter. Produces a one-cycle step pulse every p_eff
// clocks while enabled, where p_eff = max(period, 2). The clamp keeps at
// least one idle cycle between consecutive master pushes.
module ledr_step_counter
  import ledr_seq_pkg::*;
#(
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    step,
  output logic [PERIOD_WIDTH-1:0] cnt
);

  logic [PERIOD_WIDTH-1:0] reload_val;

  // Reload value is p_eff-1; periods 0 and 1 clamp to p_eff = 2.
  always_comb begin
    reload_val = period - PERIOD_WIDTH'(1);
    if (period < PERIOD_WIDTH'(2)) begin
      reload_val = PERIOD_WIDTH'(1);
    end
  end

  // Step fires in the cycle the count reaches zero.
  assign step = en && (cnt == '0);

  // Counter: load on enable, otherwise count down and reload on zero.
  // PERIOD changes are only picked up at the next reload or load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= reload_val;
    end else if (en) begin
      if (cnt == '0) begin
        cnt <= reload_val;
      end else begin
        cnt <= cnt - PERIOD_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/ledr_pattern_sequencer.sv
// Autonomous LED pattern engine. The CPU programs mode, period and pattern
// through the Avalon-MM slave; the engine steps the pattern every p_eff
// clocks and pushes each new value to the LEDR PIO through a zero-wait
// Avalon-MM master write.
//
// Handshake: the PIO slave has no waitrequest, so a master write is
// accepted in exactly the cycle where m_chipselect=1 and m_write_n=0;
// there is no back-pressure and nothing is ever held or retried. Slave
// writes are likewise accepted in any cycle with chipselect=1 and
// write_n=0, and reads are a zero-wait combinational mux on address.
module ledr_pattern_sequencer
  import ledr_seq_pkg::*;
#(
  parameter int                    LED_WIDTH     = 10,
  parameter int                    PERIOD_WIDTH  = 24,
  parameter logic [LED_WIDTH-1:0]  RESET_PATTERN = LED_WIDTH'(597),
  parameter logic [PERIOD_WIDTH-1:0] RESET_PERIOD = PERIOD_WIDTH'(12500000)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  // Configuration and pattern state
  logic                    en;
  mode_e                   mode;
  logic [PERIOD_WIDTH-1:0] period;
  logic [LED_WIDTH-1:0]    pattern;
  dir_e                    dir;

  // Push FSM state
  push_state_e             state;
  logic                    push_pend;

  // Next-state values
  logic [LED_WIDTH-1:0]    pattern_d;
  dir_e                    dir_d;

  // Slave write decode
  logic                    slave_wr;
  logic                    ctrl_wr;
  logic                    period_wr;
  logic                    pat_wr;

  // Step counter interface
  logic                    step;
  logic                    cnt_load;
  logic [PERIOD_WIDTH-1:0] step_cnt;

  // Bits of writedata above the widest register are never stored.
  logic                    unused_wdata;
  logic [PERIOD_WIDTH-1:0] unused_cnt;
  assign unused_wdata = ^writedata[31:PERIOD_WIDTH];
  assign unused_cnt   = step_cnt;

  assign slave_wr  = chipselect && !write_n;
  assign ctrl_wr   = slave_wr && (address == REG_CTRL);
  assign period_wr = slave_wr && (address == REG_PERIOD);
  assign pat_wr    = slave_wr && (address == REG_PATTERN);

  // The counter is loaded only on a 0->1 transition of en.
  assign cnt_load  = ctrl_wr && writedata[0] && !en;

  // The PIO data register always sits at master address 0.
  assign m_address = 2'b00;

  ledr_step_counter #(
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_step_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .load    (cnt_load),
    .period  (period),
    .step    (step),
    .cnt     (step_cnt)
  );

  // Next pattern/dir: a slave PATTERN write overrides any step in the same
  // cycle and resets the bounce direction to left.
  always_comb begin
    pattern_d = pattern;
    dir_d     = dir;
    if (pat_wr) begin
      pattern_d = writedata[LED_WIDTH-1:0];
      dir_d     = DIR_LEFT;
    end else if (step) begin
      case (mode)
        MODE_ROL: begin
          pattern_d = {pattern[LED_WIDTH-2:0], pattern[LED_WIDTH-1]};
        end
        MODE_ROR: begin
          pattern_d = {pattern[0], pattern[LED_WIDTH-1:1]};
        end
        MODE_BOUNCE: begin
          if ((dir == DIR_LEFT) && pattern[LED_WIDTH-1]) begin
            dir_d     = DIR_RIGHT;
            pattern_d = pattern >> 1;
          end else if ((dir == DIR_RIGHT) && pattern[0]) begin
            dir_d     = DIR_LEFT;
            pattern_d = pattern << 1;
          end else if (dir == DIR_LEFT) begin
            pattern_d = pattern << 1;
          end else begin
            pattern_d = pattern >> 1;
          end
        end
        MODE_BLINK: begin
          pattern_d = ~pattern;
        end
        default: begin
          pattern_d = pattern;
        end
      endcase
    end
  end

  // Configuration registers written from the slave port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en     <= 1'b0;
      mode   <= MODE_ROL;
      period <= RESET_PERIOD;
    end else begin
      if (ctrl_wr) begin
        en   <= writedata[0];
        mode <= mode_e'(writedata[2:1]);
      end
      if (period_wr) begin
        period <= writedata[PERIOD_WIDTH-1:0];
      end
    end
  end

  // Pattern and bounce direction follow the next-pattern logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern <= RESET_PATTERN;
      dir     <= DIR_LEFT;
    end else begin
      pattern <= pattern_d;
      dir     <= dir_d;
    end
  end

  // Push FSM: an event (step or PATTERN write) moves IDLE straight to PUSH
  // on the same edge that updates the pattern, so the master write appears
  // the cycle after the event with the new value. PUSH lasts one cycle; an
  // event landing during PUSH stays pending and is pushed from IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      push_pend    <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (push_pend || step || pat_wr) begin
            state        <= ST_PUSH;
            push_pend    <= 1'b1;
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_writedata  <= {{(32-LED_WIDTH){1'b0}}, pattern_d};
          end
        end
        ST_PUSH: begin
          state        <= ST_IDLE;
          push_pend    <= step || pat_wr;
          m_chipselect <= 1'b0;
          m_write_n    <= 1'b1;
        end
        default: begin
          state        <= ST_IDLE;
          push_pend    <= 1'b0;
          m_chipselect <= 1'b0;
          m_write_n    <= 1'b1;
        end
      endcase
    end
  end

  // Zero-wait readback mux.
  always_comb begin
    readdata = '0;
    case (address)
      REG_CTRL:    readdata = {29'b0, mode, en};
      REG_PERIOD:  readdata = {{(32-PERIOD_WIDTH){1'b0}}, period};
      REG_PATTERN: readdata = {{(32-LED_WIDTH){1'b0}}, pattern};
      REG_STATUS:  readdata = {29'b0, push_pend, (dir == DIR_RIGHT), en};
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ledr_pattern_sequencer.sv
// Directed bench for ledr_pattern_sequencer: reset state, rotate, bounce,
// blink with clamped period, PATTERN write colliding with a step, and
// asynchronous reset during a master push.
module tb_ledr_pattern_sequencer;
  import ledr_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ledr_pattern_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wr_q[$];
  int          wr_cyc_q[$];
  logic [31:0] st_q[$];

  // Record every master write with its cycle and the STATUS readback.
  always @(negedge clk) begin
    if (m_chipselect === 1'b1 && m_write_n === 1'b0) begin
      wr_q.push_back(m_writedata);
      wr_cyc_q.push_back(cyc);
      st_q.push_back(readdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    wr_q.delete();
    wr_cyc_q.delete();
    st_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Write is captured at the second posedge; returns 1ns after it.
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    @(posedge clk);
    #1;
    write_n   = 1'b1;
    address   = REG_STATUS;
    writedata = 32'h0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
    address = REG_STATUS;
  endtask

  task automatic wait_pushes(input string tag, input int n, input int budget);
    int b = 0;
    while (wr_q.size() < n && b < budget) begin
      @(posedge clk);
      b++;
    end
    check({tag, "_count_reached"}, 32'(wr_q.size() >= n), 32'd1);
  endtask

  // Pop exp_q against recorded pushes; push i expected at base+step*(i+1).
  task automatic check_pushes(input string tag, input int n, input int base, input int stp);
    for (int i = 0; i < n; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      if (i < wr_q.size()) begin
        check($sformatf("%s_val%0d", tag, i), wr_q[i], e);
        check($sformatf("%s_cyc%0d", tag, i), 32'(wr_cyc_q[i]), 32'(base + stp * (i + 1)));
      end
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] d;
    int k;

    reset_n    = 1'b0;
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = REG_STATUS;
    writedata  = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    read_reg(REG_PATTERN, d); check("rst_pattern", d, 32'd597);
    read_reg(REG_PERIOD, d);  check("rst_period", d, 32'd12500000);
    read_reg(REG_CTRL, d);    check("rst_ctrl", d, 32'd0);
    read_reg(REG_STATUS, d);  check("rst_status", d, 32'd0);
    check("rst_m_cs", 32'(m_chipselect), 32'd0);
    check("rst_m_wn", 32'(m_write_n), 32'd1);
    check("rst_m_wd", m_writedata, 32'd0);
    check("rst_m_addr", 32'(m_address), 32'd0);
    clear_q();
    repeat (1000) @(posedge clk);
    check("rst_no_writes", 32'(wr_q.size()), 32'd0);

    // Rotate-left, period 4
    write_reg(REG_PERIOD, 32'd4);
    write_reg(REG_PATTERN, 32'h001);
    @(negedge clk);
    check("patwr_m_cs", 32'(m_chipselect), 32'd1);
    check("patwr_m_wn", 32'(m_write_n), 32'd0);
    check("patwr_m_wd", m_writedata, 32'h001);
    write_reg(REG_CTRL, 32'h1);
    k = cyc;
    clear_q();
    for (int i = 0; i < 10; i++) exp_q.push_back((i == 9) ? 32'h001 : (32'h1 << (i + 1)));
    wait_pushes("rol", 10, 80);
    check_pushes("rol", 10, k, 4);

    // Disable: no further writes
    write_reg(REG_CTRL, 32'h0);
    repeat (2) @(posedge clk);
    clear_q();
    repeat (20) @(posedge clk);
    check("dis_no_writes", 32'(wr_q.size()), 32'd0);
    #1 read_reg(REG_STATUS, d); check("dis_status", d, 32'd0);

    // Bounce from 0x200, period 3
    write_reg(REG_PERIOD, 32'd3);
    write_reg(REG_PATTERN, 32'h200);
    write_reg(REG_CTRL, 32'h5);
    k = cyc;
    clear_q();
    for (int i = 0; i < 9; i++) exp_q.push_back(32'h100 >> i);
    exp_q.push_back(32'h002);
    wait_pushes("bnc", 10, 60);
    for (int i = 0; i < 10; i++) begin
      if (i < st_q.size())
        check($sformatf("bnc_status%0d", i), st_q[i], (i == 9) ? 32'd5 : 32'd7);
    end
    check_pushes("bnc", 10, k, 3);
    write_reg(REG_CTRL, 32'h0);

    // Blink with period 0 clamped to 2
    write_reg(REG_PERIOD, 32'd0);
    #1 read_reg(REG_PERIOD, d); check("blk_period_rd", d, 32'd0);
    write_reg(REG_PATTERN, 32'h255);
    write_reg(REG_CTRL, 32'h7);
    k = cyc;
    clear_q();
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 32'h1AA : 32'h255);
    wait_pushes("blk", 6, 40);
    check_pushes("blk", 6, k, 2);
    write_reg(REG_CTRL, 32'h0);
    repeat (3) @(posedge clk);

    // PATTERN write in the same cycle as a step
    write_reg(REG_PERIOD, 32'd4);
    write_reg(REG_PATTERN, 32'h001);
    write_reg(REG_CTRL, 32'h1);
    k = cyc;
    clear_q();
    repeat (2) @(posedge clk);
    write_reg(REG_PATTERN, 32'h3C0);
    exp_q.push_back(32'h3C0);
    exp_q.push_back(32'h381);
    wait_pushes("coll", 2, 20);
    check_pushes("coll", 2, k, 4);
    write_reg(REG_CTRL, 32'h0);
    repeat (3) @(posedge clk);

    // Asynchronous reset during PUSH
    write_reg(REG_PATTERN, 32'h155);
    check("arst_pre_cs", 32'(m_chipselect), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_m_cs", 32'(m_chipselect), 32'd0);
    check("arst_m_wn", 32'(m_write_n), 32'd1);
    check("arst_m_wd", m_writedata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    read_reg(REG_PATTERN, d); check("arst_pattern", d, 32'd597);
    read_reg(REG_PERIOD, d);  check("arst_period", d, 32'd12500000);
    read_reg(REG_CTRL, d);    check("arst_ctrl", d, 32'd0);
    read_reg(REG_STATUS, d);  check("arst_status", d, 32'd0);
    clear_q();
    repeat (50) @(posedge clk);
    check("arst_no_writes", 32'(wr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
